// File: rtl/multi_breath_led.sv
// Multi-channel LED controller: one shared PWM period counter drives CH_NUM channels,
// each independently off, on, breathing (ramp/hold/stagger) or blinking.
module multi_breath_led #(
    parameter int CH_NUM        = 4,
    parameter int CNT_W         = 16,
    parameter int PERIOD        = 50000,
    parameter int STEP          = 25,
    parameter int HOLD_PERIODS  = 0,
    parameter int STAGGER       = 0,
    parameter int BLINK_PERIODS = 500,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                enable,
    input  logic [2*CH_NUM-1:0] mode,
    output logic [CH_NUM-1:0]   led
);

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int AUX_MAX = maxOf(maxOf(HOLD_PERIODS, (CH_NUM - 1) * STAGGER), BLINK_PERIODS);
    localparam int AUX_W   = (AUX_MAX > 1) ? $clog2(AUX_MAX) : 1;

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(STEP);

    localparam logic [1:0] M_OFF    = 2'd0;
    localparam logic [1:0] M_ON     = 2'd1;
    localparam logic [1:0] M_BREATH = 2'd2;
    localparam logic [1:0] M_BLINK  = 2'd3;

    typedef enum logic [2:0] {
        S_WAIT,
        S_UP,
        S_HOLD_HI,
        S_DOWN,
        S_HOLD_LO
    } breathState_t;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_enPrev;
    logic              w_periodEnd;
    logic              w_restart;
    logic [CH_NUM-1:0] w_on;

    assign w_periodEnd = (r_cnt == PERIOD_C) && enable;
    // Rising enable (including the first enabled edge after reset) restarts every channel
    assign w_restart   = enable && !r_enPrev;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt    <= '0;
            r_enPrev <= 1'b0;
        end else begin
            r_enPrev <= enable;
            if (!enable || r_cnt == PERIOD_C)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        localparam int WAIT_LEN = i * STAGGER;

        logic [CNT_W-1:0] r_duty;
        logic [AUX_W-1:0] r_aux;
        logic             r_phase;
        logic [1:0]       r_curMode;
        breathState_t     r_state;
        logic [1:0]       w_modeIn;
        logic             w_chOn;

        assign w_modeIn = mode[2*i +: 2];

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst || !enable) begin
                r_duty    <= '0;
                r_aux     <= '0;
                r_phase   <= 1'b0;
                r_curMode <= M_OFF;
                r_state   <= S_UP;
            end else if (w_restart || (w_periodEnd && w_modeIn != r_curMode)) begin
                r_curMode <= w_modeIn;
                r_duty    <= '0;
                r_phase   <= 1'b0;
                r_state   <= (WAIT_LEN == 0) ? S_UP : S_WAIT;
                if (w_modeIn == M_BLINK)
                    r_aux <= AUX_W'(BLINK_PERIODS - 1);
                else if (WAIT_LEN == 0)
                    r_aux <= '0;
                else
                    r_aux <= AUX_W'(WAIT_LEN - 1);
            end else if (w_periodEnd) begin
                if (r_curMode == M_BREATH) begin
                    case (r_state)
                        S_WAIT: begin
                            if (r_aux == '0) r_state <= S_UP;
                            else             r_aux   <= r_aux - 1'b1;
                        end
                        S_UP: begin
                            if (r_duty == PERIOD_C) begin
                                r_state <= (HOLD_PERIODS == 0) ? S_DOWN : S_HOLD_HI;
                                r_aux   <= AUX_W'(HOLD_PERIODS - 1);
                            end else if (int'(r_duty) + STEP >= PERIOD) begin
                                r_duty <= PERIOD_C;
                            end else begin
                                r_duty <= r_duty + STEP_C;
                            end
                        end
                        S_HOLD_HI: begin
                            if (r_aux == '0) r_state <= S_DOWN;
                            else             r_aux   <= r_aux - 1'b1;
                        end
                        S_DOWN: begin
                            if (r_duty == '0) begin
                                r_state <= (HOLD_PERIODS == 0) ? S_UP : S_HOLD_LO;
                                r_aux   <= AUX_W'(HOLD_PERIODS - 1);
                            end else if (int'(r_duty) <= STEP) begin
                                r_duty <= '0;
                            end else begin
                                r_duty <= r_duty - STEP_C;
                            end
                        end
                        S_HOLD_LO: begin
                            if (r_aux == '0) r_state <= S_UP;
                            else             r_aux   <= r_aux - 1'b1;
                        end
                        default: r_state <= S_UP;
                    endcase
                end else if (r_curMode == M_BLINK) begin
                    if (r_aux == '0) begin
                        r_phase <= ~r_phase;
                        r_aux   <= AUX_W'(BLINK_PERIODS - 1);
                    end else begin
                        r_aux <= r_aux - 1'b1;
                    end
                end
            end
        end

        always_comb begin
            w_chOn = 1'b0;
            case (r_curMode)
                M_OFF:    w_chOn = 1'b0;
                M_ON:     w_chOn = 1'b1;
                M_BREATH: w_chOn = (r_cnt < r_duty);
                M_BLINK:  w_chOn = r_phase;
                default:  w_chOn = 1'b0;
            endcase
        end

        assign w_on[i] = w_chOn;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst || !enable)
            led <= {CH_NUM{ACTIVE_LOW}};
        else
            led <= w_on ^ {CH_NUM{ACTIVE_LOW}};
    end

endmodule

// File: tb/tb_multi_breath_led.sv
// Bench for multi_breath_led: two instances (STEP=3 and STEP=4) share stimulus;
// per-period active-clock counts are compared against a hand-computed table.
module tb_multi_breath_led;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] mode;
    logic [1:0] led1;
    logic [1:0] led2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] mode;
        bit         glitch;
        int         c0a;
        int         c1a;
        int         c0b;
        int         c1b;
    } vec_t;

    vec_t vecs[27];

    always #5 clk = ~clk;

    multi_breath_led #(
        .CH_NUM(2), .CNT_W(16), .PERIOD(9), .STEP(3), .HOLD_PERIODS(1),
        .STAGGER(2), .BLINK_PERIODS(2), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .sys_clk(clk), .sys_rst(rst), .enable(enable), .mode(mode), .led(led1)
    );

    multi_breath_led #(
        .CH_NUM(2), .CNT_W(16), .PERIOD(9), .STEP(4), .HOLD_PERIODS(1),
        .STAGGER(2), .BLINK_PERIODS(2), .ACTIVE_LOW(1'b1)
    ) dut2 (
        .sys_clk(clk), .sys_rst(rst), .enable(enable), .mode(mode), .led(led2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One PWM period: count active (low) clocks per channel; mode is updated mid-period.
    task automatic applyStimulus(input vec_t v, input string tag);
        int n0a = 0;
        int n1a = 0;
        int n0b = 0;
        int n1b = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (led1[0] == 1'b0) n0a++;
            if (led1[1] == 1'b0) n1a++;
            if (led2[0] == 1'b0) n0b++;
            if (led2[1] == 1'b0) n1b++;
            if (v.glitch && k == 3) mode = {2'b00, mode[1:0]};
            if (k == 5) mode = v.mode;
        end
        checkOutput({tag, " ch0 step3"}, n0a, v.c0a);
        checkOutput({tag, " ch1 step3"}, n1a, v.c1a);
        checkOutput({tag, " ch0 step4"}, n0b, v.c0b);
        checkOutput({tag, " ch1 step4"}, n1b, v.c1b);
    endtask

    initial begin
        // breathing from reset release, then ch0 -> on mid period 12 with a ch1 glitch
        vecs[0]  = '{4'b1010, 1'b0,  0, 0,  0, 0};
        vecs[1]  = '{4'b1010, 1'b0,  3, 0,  4, 0};
        vecs[2]  = '{4'b1010, 1'b0,  6, 0,  8, 0};
        vecs[3]  = '{4'b1010, 1'b0,  9, 3,  9, 4};
        vecs[4]  = '{4'b1010, 1'b0,  9, 6,  9, 8};
        vecs[5]  = '{4'b1010, 1'b0,  9, 9,  9, 9};
        vecs[6]  = '{4'b1010, 1'b0,  6, 9,  5, 9};
        vecs[7]  = '{4'b1010, 1'b0,  3, 9,  1, 9};
        vecs[8]  = '{4'b1010, 1'b0,  0, 6,  0, 5};
        vecs[9]  = '{4'b1010, 1'b0,  0, 3,  0, 1};
        vecs[10] = '{4'b1010, 1'b0,  0, 0,  0, 0};
        vecs[11] = '{4'b1010, 1'b0,  3, 0,  4, 0};
        vecs[12] = '{4'b1001, 1'b1,  6, 0,  8, 0};
        vecs[13] = '{4'b1001, 1'b0, 10, 3, 10, 4};
        vecs[14] = '{4'b1001, 1'b0, 10, 6, 10, 8};
        // restart after enable re-rises
        vecs[15] = '{4'b1010, 1'b0,  0, 0,  0, 0};
        vecs[16] = '{4'b1010, 1'b0,  3, 0,  4, 0};
        vecs[17] = '{4'b1010, 1'b0,  6, 0,  8, 0};
        vecs[18] = '{4'b1010, 1'b0,  9, 3,  9, 4};
        // ch0 blink, ch1 breath
        vecs[19] = '{4'b1011, 1'b0,  0, 0,  0, 0};
        vecs[20] = '{4'b1011, 1'b0,  0, 0,  0, 0};
        vecs[21] = '{4'b1011, 1'b0, 10, 0, 10, 0};
        vecs[22] = '{4'b1011, 1'b0, 10, 3, 10, 4};
        vecs[23] = '{4'b1011, 1'b0,  0, 6,  0, 8};
        vecs[24] = '{4'b1011, 1'b0,  0, 9,  0, 9};
        vecs[25] = '{4'b1011, 1'b0, 10, 9, 10, 9};
        vecs[26] = '{4'b1011, 1'b0, 10, 9, 10, 9};

        rst    = 1'b1;
        enable = 1'b1;
        mode   = 4'b1010;
        @(negedge clk);
        checkOutput("reset led1 early", led1, 2'b11);
        repeat (2) @(negedge clk);
        checkOutput("reset led1", led1, 2'b11);
        checkOutput("reset led2", led2, 2'b11);
        checkOutput("reset cnt", dut1.r_cnt, 0);
        rst = 1'b0;

        for (int p = 0; p < 15; p++)
            applyStimulus(vecs[p], $sformatf("breath p%0d", p));

        // last sample was the wrap edge; dropping enable must hold cnt at 0
        enable = 1'b0;
        @(negedge clk);
        checkOutput("disable led1", led1, 2'b11);
        checkOutput("disable led2", led2, 2'b11);
        checkOutput("disable cnt", dut1.r_cnt, 0);
        repeat (3) @(negedge clk);
        checkOutput("disabled led1 hold", led1, 2'b11);
        checkOutput("disabled cnt hold", dut1.r_cnt, 0);
        mode   = 4'b1010;
        enable = 1'b1;

        for (int p = 15; p < 19; p++)
            applyStimulus(vecs[p], $sformatf("restart p%0d", p - 15));

        // two clocks into the hold-high period ch0 is active; reset between edges
        repeat (2) @(negedge clk);
        checkOutput("pre-reset ch0 active", led1[0], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset led1", led1, 2'b11);
        checkOutput("async reset led2", led2, 2'b11);
        checkOutput("async reset cnt", dut1.r_cnt, 0);
        mode = 4'b1011;
        @(negedge clk);
        checkOutput("reset held led1", led1, 2'b11);
        rst = 1'b0;

        for (int p = 19; p < 27; p++)
            applyStimulus(vecs[p], $sformatf("blink p%0d", p - 19));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_breath_led.md
# multi_breath_led

Parametrised multi-channel LED brightness controller, next generation of the single-channel 1 kHz breathing LED. One shared PWM period counter drives CH_NUM independent channels. Each channel is set per mode to off, steady on, breathing with configurable step, peak/trough hold and per-channel phase stagger, or blink. It sits between board-level control logic and the LED pins.

## Interface
- CH_NUM, 4: number of LED channels (1..16).
- CNT_W, 16: width of the period counter and duty registers.
- PERIOD, 50000: terminal count. The PWM period is PERIOD+1 clocks (1 ms at 50 MHz).
- STEP, 25: duty increment or decrement applied per period while ramping.
- HOLD_PERIODS, 0: extra periods spent at peak and at trough (0 means no hold state).
- STAGGER, 0: breathing start delay between adjacent channels, in periods. Channel i waits i*STAGGER periods.
- BLINK_PERIODS, 500: periods per blink half-cycle (must be at least 1).
- ACTIVE_LOW, 1: when 1, an LED that is on drives 0.
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- enable  in  1  global run. Low clears the counter and all channel state, and forces every LED inactive.
- mode  in  2*CH_NUM  bits [2i+1:2i] select channel i: 0 off, 1 on, 2 breath, 3 blink.
- led  out  CH_NUM  registered LED drive.

## Operation
- Period counter cnt runs 0..PERIOD and then wraps to 0. period_end = (cnt == PERIOD) && enable. While enable is low, cnt is held at 0.
- Per-channel registers: duty[CNT_W-1:0], state, aux counter (wait, hold or blink), blink phase bit, and a registered copy of the mode (cur_mode).
- Mode sampling: the mode input is sampled only on period_end. If the new mode differs from cur_mode, the channel restarts in that mode:
  - duty is set to 0.
  - blink phase is set to 0.
  - The breath state is set to WAIT, with aux = i*STAGGER-1, or to UP if i*STAGGER is 0.
- The rising edge of enable and the release of sys_rst apply the same restart using the current mode input.
- Breath FSM: all transitions and duty updates happen only on period_end.
  - WAIT: decrement aux. At aux==0, go to UP.
  - UP: if duty==PERIOD, go to HOLD_HI with aux=HOLD_PERIODS-1, or go directly to DOWN if HOLD_PERIODS==0. Otherwise duty = min(duty+STEP, PERIOD).
  - HOLD_HI: decrement aux. At aux==0, go to DOWN.
  - DOWN: if duty==0, go to HOLD_LO with aux=HOLD_PERIODS-1, or go directly to UP if HOLD_PERIODS==0. Otherwise duty = (duty<STEP) ? 0 : duty-STEP.
  - HOLD_LO: decrement aux. At aux==0, go to UP.
- Duty arithmetic saturates at both ends. No wrap is possible for any PERIOD/STEP pair. PERIOD must not exceed 2^CNT_W-1.
- Blink: on period_end, decrement aux (loaded with BLINK_PERIODS-1). At 0, toggle phase and reload aux.
- Per-channel on condition:
  - off: 0.
  - on: 1.
  - breath: cnt < duty.
  - blink: phase.
- led[i] is registered as on^ACTIVE_LOW.

## Timing
- Reset values: cnt=0, duty=0, phase=0, aux=0, cur_mode=0 (off). led = {CH_NUM{ACTIVE_LOW}}, i.e. all LEDs inactive.
- led latency: led at edge t+1 reflects cnt and duty present at edge t. No other pipeline stages.
- A duty update on period_end takes effect from the following cnt==0.
- enable falling: on the next edge, cnt=0, duty=0 and all LEDs go inactive. A simultaneous period_end is ignored.
- sys_rst asserted mid-ramp: everything returns to reset values immediately, with no wait for a clock edge.
- A mode change that occurs in the same cycle as a period_end is sampled in that cycle. A mode input toggling between period_ends is ignored.

## Test plan
Common parameters: PERIOD=9, STEP=3, CH_NUM=2, HOLD_PERIODS=1, STAGGER=2, BLINK_PERIODS=2, ACTIVE_LOW=1.

- Reset: hold sys_rst high, then release with enable=1 and mode=2'b10_10.
  - Required led=2'b11 throughout reset.
  - Ch0 duty per period: 0,3,6,9,9,9,6,3,0,0,0,3. The peak and trough holds follow from HOLD_PERIODS=1.
  - On-clocks per period equal duty.
- Stagger: same run as above.
  - Ch1 duty stays 0 for periods 0..2.
  - Ch1 duty is 3 in period 3 and reaches 9 in period 5.
- Blink: set mode ch0=3 (blink) and check ch0's led.
  - Inactive (led=1) for 2 periods, then active (led=0) for 2 periods, repeating.
  - Edges are aligned to cnt==0, one clock after the wrap.
- Saturation: use STEP=4.
  - Up sequence: 0,4,8,9 (clamped).
  - Down sequence: 9,5,1,0 (clamped).
- Mode change and enable:
  - Change ch0 from breath to on mid-period. Ch0 switches only after the next period_end, then stays at led=0 (active).
  - Drop enable. On the next edge, led=2'b11 and cnt=0.
  - Raise enable. Ch0 restarts its sequence from its first state.
- Async reset mid-ramp: assert sys_rst between clock edges. led=2'b11 immediately, with no clock edge needed.
